mat_dispatch: RTL

Matrix-instruction dispatch stage sitting directly upstream of the matrix register status table (`rst_m`). It accepts one decoded matrix instruction at a time and holds it until no source or destination register is busy and a free tag exists. It then allocates the tag, pulses the status-table write (`di_write`/`di_sel`/`di_tag`), and hands the instruction to the matrix functional unit over a valid/ready handshake. Tags return to the free pool on writeback.

---
 rtl/mat_dispatch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mat_dispatch.sv
// mat_dispatch: holds one decoded matrix instruction until its registers are
// hazard-free and a tag is available, allocates the tag into the register
// status table, then issues the instruction to the matrix FU.
// Optional feature macro: MAT_DISPATCH_WB_BYPASS_EN lets a same-cycle
// writeback clear a busy bit so dispatch can happen in the writeback cycle.
module mat_dispatch #(
  parameter  int NREGS = 16,
  parameter  int NTAGS = 8,
  parameter  int OPW   = 4,
  localparam int RW    = $clog2(NREGS),
  localparam int TW    = $clog2(NTAGS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [RW-1:0]    in_rd,
  input  logic [RW-1:0]    in_rs1,
  input  logic [RW-1:0]    in_rs2,
  input  logic [RW-1:0]    in_rs3,
  input  logic             in_flush,
  input  logic [NREGS-1:0] rst_busy,
  output logic             di_write,
  output logic [RW-1:0]    di_sel,
  output logic [TW-1:0]    di_tag,
  input  logic             wb_write,
  input  logic [RW-1:0]    wb_sel,
  input  logic [TW-1:0]    wb_tag,
  output logic             fu_valid,
  input  logic             fu_ready,
  output logic [OPW-1:0]   fu_op,
  output logic [RW-1:0]    fu_rd,
  output logic [RW-1:0]    fu_rs1,
  output logic [RW-1:0]    fu_rs2,
  output logic [RW-1:0]    fu_rs3,
  output logic [TW-1:0]    fu_tag
);

  typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;

  // Tag 0 means "no producer" and never appears in the free map.
  localparam logic [NTAGS-1:0] ALL_FREE = {{(NTAGS-1){1'b1}}, 1'b0};

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [RW-1:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [TW-1:0]    fu_tag_q, fu_tag_d;
  logic [NTAGS-1:0] free_q, free_d;

  logic [NREGS-1:0] eff_busy;
  logic [NTAGS-1:0] wb_mask, free_eff;
  logic             hazard;
  logic [TW-1:0]    tag_sel;
  logic             tag_found;

`ifdef MAT_DISPATCH_WB_BYPASS_EN
  // A register being written back this cycle is treated as no longer busy.
  always_comb begin
    eff_busy = rst_busy & ~(wb_write ? (NREGS'(1) << wb_sel) : '0);
  end
`else
  logic unused_wb_sel;
  assign unused_wb_sel = ^wb_sel;

  // Busy bits are taken as-is; a writeback shows up a cycle later via the table.
  always_comb begin
    eff_busy = rst_busy;
  end
`endif

  // Retiring tag joins the pool immediately; pick the lowest free tag.
  always_comb begin
    wb_mask   = (wb_write && (wb_tag != '0)) ? (NTAGS'(1) << wb_tag) : '0;
    free_eff  = (free_q | wb_mask) & ALL_FREE;
    tag_sel   = '0;
    tag_found = 1'b0;
    for (int i = NTAGS - 1; i >= 1; i--) begin
      if (free_eff[i]) begin
        tag_sel   = TW'(i);
        tag_found = 1'b1;
      end
    end
    hazard = eff_busy[rs1_q] | eff_busy[rs2_q] | eff_busy[rs3_q] | eff_busy[rd_q];
  end

  // Next-state, hold-register capture, tag allocation and handshake outputs.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rs3_d    = rs3_q;
    fu_tag_d = fu_tag_q;
    free_d   = free_eff;
    in_ready = 1'b0;
    di_write = 1'b0;
    fu_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          rs3_d   = in_rs3;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Flush wins over a dispatch that would otherwise happen this cycle.
        if (in_flush) begin
          state_d = IDLE;
        end else if (!hazard && tag_found) begin
          di_write        = 1'b1;
          free_d[tag_sel] = 1'b0;
          fu_tag_d        = tag_sel;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        fu_valid = 1'b1;
        if (fu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, hold register, issued tag and free map; reset discards everything.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      fu_tag_q <= '0;
      free_q   <= ALL_FREE;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rs3_q    <= rs3_d;
      fu_tag_q <= fu_tag_d;
      free_q   <= free_d;
    end
  end

  assign di_sel = rd_q;
  assign di_tag = tag_sel;
  assign fu_op  = op_q;
  assign fu_rd  = rd_q;
  assign fu_rs1 = rs1_q;
  assign fu_rs2 = rs2_q;
  assign fu_rs3 = rs3_q;
  assign fu_tag = fu_tag_q;

endmodule
